// File: rtl/ir_shot_encoder_if.sv
// APB slave bus bundle for the IR shot encoder.
interface ir_shot_encoder_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ir_shot_encoder.sv
// APB-controlled IR shot transmitter: sends a 3-bit mark-length-coded frame on ir_out.
// Optional macro IR_CARRIER_EN gates the mark with an on-chip carrier of CARRIER_HALF half-period.
module ir_shot_encoder #(
  parameter int unsigned MARK_SHORT   = 17500,
  parameter int unsigned MARK_LONG    = 52500,
  parameter int unsigned SLOT_LEN     = 70000,
  parameter int unsigned COOLDOWN     = 1000000,
  parameter int unsigned CARRIER_HALF = 1316
) (
  input  logic               PCLK,
  input  logic               PRESET,
  ir_shot_encoder_if.slave   apb,
  output logic               ir_out,
  output logic               busy,
  output logic               shot_done_int
);

  if (MARK_SHORT == 0 || MARK_LONG <= MARK_SHORT || SLOT_LEN <= MARK_LONG ||
      COOLDOWN == 0 || CARRIER_HALF == 0) begin : g_param_check
    $error("ir_shot_encoder: inconsistent timing parameters");
  end

  typedef enum logic [1:0] {StIdle, StMark, StSpace, StCool} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  frame_q, frame_d;
  logic [31:0] id_q;
  logic [1:0]  payload_q;
  logic        dropped_q;
  logic        ir_out_q, ir_out_d;

  logic        wr, fire_wr, accept, clr_drop;
  logic [31:0] mark_len, dur;
  logic        last;

  assign wr       = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign fire_wr  = wr && (apb.PADDR == 8'h04);
  assign accept   = fire_wr && (state_q == StIdle);
  assign clr_drop = wr && (apb.PADDR == 8'h08) && apb.PWDATA[1];

  assign mark_len = frame_q[idx_q] ? 32'(MARK_LONG) : 32'(MARK_SHORT);

  always_comb begin
    dur = 32'd0;
    unique case (state_q)
      StMark:  dur = mark_len;
      StSpace: dur = 32'(SLOT_LEN) - mark_len;
      StCool:  dur = 32'(COOLDOWN);
      default: dur = 32'd0;
    endcase
  end

  assign last = (cnt_q == dur - 32'd1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 32'd1;
    idx_d         = idx_q;
    frame_d       = frame_q;
    shot_done_int = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = 32'd0;
        if (accept) begin
          frame_d = {~id_q[0], apb.PWDATA[1:0]};
          idx_d   = 2'd2;
          state_d = StMark;
        end
      end
      StMark: begin
        if (last) begin
          cnt_d   = 32'd0;
          state_d = StSpace;
        end
      end
      StSpace: begin
        if (last) begin
          cnt_d = 32'd0;
          if (idx_q != 2'd0) begin
            idx_d   = idx_q - 2'd1;
            state_d = StMark;
          end else begin
            shot_done_int = 1'b1;
            idx_d         = 2'd2;
            state_d       = StCool;
          end
        end
      end
      StCool: begin
        if (last) begin
          cnt_d   = 32'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef IR_CARRIER_EN
  logic [31:0] car_q, car_d;

  // Divider restarts on every mark entry so each mark begins with a full high half-period.
  always_comb begin
    car_d    = 32'd0;
    ir_out_d = 1'b0;
    if (state_d == StMark) begin
      if (state_q != StMark) begin
        ir_out_d = 1'b1;
      end else if (car_q == 32'(CARRIER_HALF) - 32'd1) begin
        ir_out_d = ~ir_out_q;
      end else begin
        car_d    = car_q + 32'd1;
        ir_out_d = ir_out_q;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) car_q <= 32'd0;
    else        car_q <= car_d;
  end
`else
  always_comb begin
    ir_out_d = (state_d == StMark);
  end
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= StIdle;
      cnt_q     <= 32'd0;
      idx_q     <= 2'd2;
      frame_q   <= 3'd0;
      ir_out_q  <= 1'b0;
      id_q      <= 32'd0;
      payload_q <= 2'd0;
      dropped_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      ir_out_q <= ir_out_d;
      if (wr && (apb.PADDR == 8'h00)) id_q <= apb.PWDATA;
      if (accept) payload_q <= apb.PWDATA[1:0];
      // A new drop beats a simultaneous clear.
      if (fire_wr && (state_q != StIdle)) dropped_q <= 1'b1;
      else if (clr_drop)                  dropped_q <= 1'b0;
    end
  end

  assign ir_out = ir_out_q;
  assign busy   = (state_q != StIdle);

  always_comb begin
    apb.PRDATA = 32'd0;
    unique case (apb.PADDR)
      8'h00:   apb.PRDATA = id_q;
      8'h04:   apb.PRDATA = {30'd0, payload_q};
      8'h08:   apb.PRDATA = {30'd0, dropped_q, busy};
      default: apb.PRDATA = 32'd0;
    endcase
  end

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;

endmodule

// File: tb/tb_ir_shot_encoder.sv
// Randomized bench for ir_shot_encoder against a cycle-offset reference model.
module tb_ir_shot_encoder;
  localparam int MS = 4;
  localparam int ML = 12;
  localparam int SL = 16;
  localparam int CD = 8;
  localparam int CH = 2;

  logic PCLK = 1'b0;
  logic PRESET;
  logic ir_out, busy, shot_done_int;

  ir_shot_encoder_if apb ();

  ir_shot_encoder #(
    .MARK_SHORT   (MS),
    .MARK_LONG    (ML),
    .SLOT_LEN     (SL),
    .COOLDOWN     (CD),
    .CARRIER_HALF (CH)
  ) dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .apb           (apb),
    .ir_out        (ir_out),
    .busy          (busy),
    .shot_done_int (shot_done_int)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;

  // Model: a frame is fully described by the cycle it was accepted in.
  int          cyc  = 0;
  int          acc  = -1;
  bit          live = 1'b0;
  logic [2:0]  m_frame = 3'd0;
  logic [31:0] m_id = 32'd0;
  logic [1:0]  m_pay = 2'd0;
  logic        m_drop = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int offs();
    return cyc - acc - 1;
  endfunction

  function automatic logic m_busy();
    int s;
    s = offs();
    return (acc >= 0) && (s >= 0) && (s < 3 * SL + CD);
  endfunction

  function automatic logic m_ir();
    int   s, pos, len;
    logic b;
    if (!m_busy()) return 1'b0;
    s = offs();
    if (s >= 3 * SL) return 1'b0;
    b   = m_frame[2 - s / SL];
    len = b ? ML : MS;
    pos = s % SL;
    if (pos >= len) return 1'b0;
`ifdef IR_CARRIER_EN
    return ((pos / CH) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic m_done();
    return m_busy() && (offs() == 3 * SL - 1);
  endfunction

  function automatic logic [31:0] m_rdata(input logic [7:0] addr);
    case (addr)
      8'h00:   return m_id;
      8'h04:   return {30'd0, m_pay};
      8'h08:   return {30'd0, m_drop, m_busy()};
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_cycle(input logic sel, input logic en, input logic wr,
                          input logic [7:0] addr, input logic [31:0] data, input logic rst);
    logic bsy;
    apb.PSEL    = sel;
    apb.PENABLE = en;
    apb.PWRITE  = wr;
    apb.PADDR   = addr;
    apb.PWDATA  = data;
    PRESET      = rst;
    @(negedge PCLK);
    if (live) begin
      check_eq("ir_out", 32'(ir_out), 32'(m_ir()));
      check_eq("busy", 32'(busy), 32'(m_busy()));
      check_eq("shot_done_int", 32'(shot_done_int), 32'(m_done()));
      check_eq("prdata", apb.PRDATA, m_rdata(addr));
      check_eq("pready", 32'(apb.PREADY), 32'd1);
      check_eq("pslverr", 32'(apb.PSLVERR), 32'd0);
    end
    @(posedge PCLK);
    bsy = m_busy();
    if (rst) begin
      acc    = -1;
      m_id   = 32'd0;
      m_pay  = 2'd0;
      m_drop = 1'b0;
      live   = 1'b1;
    end else if (live && sel && en && wr) begin
      case (addr)
        8'h00: m_id = data;
        8'h04: begin
          if (!bsy) begin
            acc     = cyc;
            m_frame = {~m_id[0], data[1:0]};
            m_pay   = data[1:0];
          end else begin
            m_drop = 1'b1;
          end
        end
        8'h08: if (data[1]) m_drop = 1'b0;
        default: ;
      endcase
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) do_cycle(1'b0, 1'b0, 1'b0, 8'((i % 3) * 4), 32'd0, 1'b0);
  endtask

  task automatic apb_wr(input logic [7:0] addr, input logic [31:0] data);
    do_cycle(1'b1, 1'b1, 1'b1, addr, data, 1'b0);
  endtask

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = 8'h00; apb.PWDATA = 32'd0; PRESET = 1'b1;
    @(posedge PCLK);
    #1;
    do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b0, 8'h08, 32'd0, 1'b1);
    idle(3);

    // ID=0, FIRE 2 -> frame 110
    apb_wr(8'h00, 32'd0);
    apb_wr(8'h04, 32'h2);
    idle(60);

    // ID=1, FIRE 1 -> frame 001, then FIRE in bit1 space and clear
    apb_wr(8'h00, 32'd1);
    apb_wr(8'h04, 32'h1);
    idle(28);
    apb_wr(8'h04, 32'h3);
    idle(2);
    apb_wr(8'h08, 32'h2);
    idle(40);

    // FIRE exactly at cooldown exit is dropped; one cycle later is accepted
    apb_wr(8'h04, 32'h0);
    idle(55);
    apb_wr(8'h04, 32'h1);
    apb_wr(8'h04, 32'h2);
    idle(70);

    // Reset during bit1 mark, then a fresh frame
    apb_wr(8'h00, 32'hA5A5_A5A4);
    apb_wr(8'h04, 32'h3);
    idle(18);
    do_cycle(1'b0, 1'b0, 1'b0, 8'h08, 32'd0, 1'b1);
    idle(2);
    apb_wr(8'h04, 32'h2);
    idle(60);

    for (int i = 0; i < 3000; i++) begin
      int          r;
      logic [31:0] d;
      r = $urandom_range(0, 99);
      d = $urandom;
      if (r < 1)       do_cycle(1'b0, 1'b0, 1'b0, 8'h00, d, 1'b1);
      else if (r < 8)  apb_wr(8'h04, d);
      else if (r < 11) apb_wr(8'h00, d);
      else if (r < 14) apb_wr(8'h08, d);
      else if (r < 18) do_cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                8'($urandom_range(0, 15)), d, 1'b0);
      else             do_cycle(1'b0, 1'b0, 1'b0, 8'($urandom_range(0, 3) * 4), d, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
